// File: rtl/gpu_pwr_pkg.sv
// Shared types and helpers for the e-GPU clock/reset power sequencer.
package gpu_pwr_pkg;

  typedef enum logic [2:0] {
    TOP_IDLE,
    TOP_START,
    TOP_L2_CLK,
    TOP_L2_RUN,
    TOP_L2_RST,
    TOP_DONE
  } top_state_t;

  typedef enum logic [2:0] {
    CU_OFF,
    CU_CLK,
    CU_RUN,
    CU_RST
  } cu_state_t;

  // Counter width wide enough to hold the larger delay minus one without wrapping.
  function automatic int unsigned cnt_width(input int unsigned clk_delay,
                                            input int unsigned rst_delay);
    int unsigned max_d;
    max_d = (clk_delay > rst_delay) ? clk_delay : rst_delay;
    return $clog2(max_d) + 1;
  endfunction

endpackage

// File: rtl/cu_pwr_fsm.sv
// One compute-unit power channel: clock/reset sequencing FSM, delay counter and sticky sleep bit.
module cu_pwr_fsm
  import gpu_pwr_pkg::*;
#(
  parameter int unsigned CLK_DELAY = 4,
  parameter int unsigned RST_DELAY = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_launch,
  input  logic i_clear,
  input  logic i_abort,
  input  logic i_sleep_req,
  input  logic i_delay_sleep,
  output logic o_clk_en,
  output logic o_rst_n,
  output logic o_off
);

  localparam int unsigned CNT_W = cnt_width(CLK_DELAY, RST_DELAY);
  localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLK_DELAY - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_DELAY - 1);

  cu_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sleep;
  logic             r_clk_en;
  logic             r_rst_n;

  // Sticky sleep request; a new launch clears it even if a request arrives the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sleep <= 1'b0;
    end else if (i_clear) begin
      r_sleep <= 1'b0;
    end else if (i_sleep_req) begin
      r_sleep <= 1'b1;
    end
  end

  // Channel sequence OFF -> CLK -> RUN -> RST -> OFF with outputs registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= CU_OFF;
      r_cnt    <= '0;
      r_clk_en <= 1'b0;
      r_rst_n  <= 1'b0;
    end else begin
      case (r_state)
        CU_OFF: begin
          if (i_launch) begin
            r_state  <= CU_CLK;
            r_cnt    <= '0;
            r_clk_en <= 1'b1;
            r_rst_n  <= 1'b0;
          end
        end
        CU_CLK: begin
          if (r_cnt == CLK_LAST) begin
            r_state <= CU_RUN;
            r_rst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CU_RUN: begin
          if ((r_sleep && !i_delay_sleep) || i_abort) begin
            r_state <= CU_RST;
            r_cnt   <= '0;
            r_rst_n <= 1'b0;
          end
        end
        CU_RST: begin
          if (r_cnt == RST_LAST) begin
            r_state  <= CU_OFF;
            r_clk_en <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= CU_OFF;
          r_cnt    <= '0;
          r_clk_en <= 1'b0;
          r_rst_n  <= 1'b0;
        end
      endcase
    end
  end

  assign o_clk_en = r_clk_en;
  assign o_rst_n  = r_rst_n;
  assign o_off    = (r_state == CU_OFF);

endmodule

// File: rtl/gpu_pwr_seq.sv
// e-GPU power sequencer top: L2 clock/reset FSM, launch mask, abort tracking and per-CU channels.
module gpu_pwr_seq
  import gpu_pwr_pkg::*;
#(
  parameter int unsigned NUM_CU    = 4,
  parameter int unsigned CLK_DELAY = 4,
  parameter int unsigned RST_DELAY = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              gpu_start_i,
  input  logic              gpu_abort_i,
  input  logic [NUM_CU-1:0] cu_mask_i,
  input  logic [NUM_CU-1:0] cu_sleep_req_i,
  input  logic [NUM_CU-1:0] cu_delay_sleep_i,
  output logic [NUM_CU-1:0] cu_clk_en_o,
  output logic [NUM_CU-1:0] cu_rst_n_o,
  output logic              l2_clk_en_o,
  output logic              l2_rst_n_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CNT_W = cnt_width(CLK_DELAY, RST_DELAY);
  localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLK_DELAY - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_DELAY - 1);

  top_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CU-1:0] r_mask;
  logic              r_abort_pending;
  logic              r_busy;
  logic              r_done;
  logic              r_l2_clk_en;
  logic              r_l2_rst_n;

  logic              w_start;
  logic              w_all_off;
  logic [NUM_CU-1:0] w_cu_off;

  assign w_start   = (r_state == TOP_START);
  // Unmasked channels never leave OFF, so they are excluded from the completion test.
  assign w_all_off = &(w_cu_off | ~r_mask);

  for (genvar g = 0; g < NUM_CU; g++) begin : g_cu
    cu_pwr_fsm #(
      .CLK_DELAY (CLK_DELAY),
      .RST_DELAY (RST_DELAY)
    ) u_cu (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .i_launch      (w_start & r_mask[g]),
      .i_clear       (w_start),
      .i_abort       (r_abort_pending),
      .i_sleep_req   (cu_sleep_req_i[g]),
      .i_delay_sleep (cu_delay_sleep_i[g]),
      .o_clk_en      (cu_clk_en_o[g]),
      .o_rst_n       (cu_rst_n_o[g]),
      .o_off         (w_cu_off[g])
    );
  end

  // Abort is only meaningful during a launch and is retired when the sequence completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_abort_pending <= 1'b0;
    end else if (r_state == TOP_DONE) begin
      r_abort_pending <= 1'b0;
    end else if (gpu_abort_i && r_busy) begin
      r_abort_pending <= 1'b1;
    end
  end

  // L2 sequence IDLE -> START -> L2_CLK -> L2_RUN -> L2_RST -> DONE with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= TOP_IDLE;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_l2_clk_en <= 1'b0;
      r_l2_rst_n  <= 1'b0;
    end else begin
      case (r_state)
        TOP_IDLE: begin
          if (gpu_start_i && |cu_mask_i) begin
            r_state <= TOP_START;
            r_mask  <= cu_mask_i;
            r_busy  <= 1'b1;
          end
        end
        TOP_START: begin
          r_state     <= TOP_L2_CLK;
          r_cnt       <= '0;
          r_l2_clk_en <= 1'b1;
          r_l2_rst_n  <= 1'b0;
        end
        TOP_L2_CLK: begin
          if (r_cnt == CLK_LAST) begin
            r_state    <= TOP_L2_RUN;
            r_l2_rst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TOP_L2_RUN: begin
          if (w_all_off) begin
            r_state    <= TOP_L2_RST;
            r_cnt      <= '0;
            r_l2_rst_n <= 1'b0;
          end
        end
        TOP_L2_RST: begin
          if (r_cnt == RST_LAST) begin
            r_state     <= TOP_DONE;
            r_l2_clk_en <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TOP_DONE: begin
          r_state <= TOP_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= TOP_IDLE;
          r_cnt       <= '0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_l2_clk_en <= 1'b0;
          r_l2_rst_n  <= 1'b0;
        end
      endcase
    end
  end

  assign l2_clk_en_o = r_l2_clk_en;
  assign l2_rst_n_o  = r_l2_rst_n;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule

// File: tb/tb_gpu_pwr_seq.sv
// Self-checking bench for gpu_pwr_seq: timestamp-based reference model plus directed literal checks.
module tb_gpu_pwr_seq;

  localparam int unsigned NCU   = 4;
  localparam int          CLK_D = 4;
  localparam int          RST_D = 4;
  localparam int          LOGN  = 16384;

  localparam int SEL_BUSY  = 0;
  localparam int SEL_CLK   = 1;
  localparam int SEL_RSTN  = 2;
  localparam int SEL_DONE  = 3;
  localparam int SEL_L2RN  = 4;
  localparam int SEL_L2CLK = 5;
  localparam int SEL_ABORT = 6;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           gpu_start_i = 1'b0;
  logic           gpu_abort_i = 1'b0;
  logic [NCU-1:0] cu_mask_i = '0;
  logic [NCU-1:0] cu_sleep_req_i = '0;
  logic [NCU-1:0] cu_delay_sleep_i = '0;
  logic [NCU-1:0] cu_clk_en_o;
  logic [NCU-1:0] cu_rst_n_o;
  logic           l2_clk_en_o;
  logic           l2_rst_n_o;
  logic           busy_o;
  logic           done_o;

  always #5 clk = ~clk;

  gpu_pwr_seq #(
    .NUM_CU    (NCU),
    .CLK_DELAY (CLK_D),
    .RST_DELAY (RST_D)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .gpu_start_i      (gpu_start_i),
    .gpu_abort_i      (gpu_abort_i),
    .cu_mask_i        (cu_mask_i),
    .cu_sleep_req_i   (cu_sleep_req_i),
    .cu_delay_sleep_i (cu_delay_sleep_i),
    .cu_clk_en_o      (cu_clk_en_o),
    .cu_rst_n_o       (cu_rst_n_o),
    .l2_clk_en_o      (l2_clk_en_o),
    .l2_rst_n_o       (l2_rst_n_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a launch is described by the cycle it started (t0), the cycle each
  // CU entered its reset phase (tcr) and the cycle the L2 entered reset (trst); every
  // output is an interval test on the current cycle number against those timestamps.
  int             tnow = 0;
  bit             act = 1'b0;
  int             t0 = 0;
  int             trst = -1;
  int             tcr[NCU];
  logic [NCU-1:0] mmask = '0;
  logic [NCU-1:0] msleep = '0;
  bit             mabort = 1'b0;

  function automatic bit m_cu_on(input int i, input int t);
    return act && mmask[i] && (t >= t0 + 1) && !(tcr[i] >= 0 && t >= tcr[i] + RST_D);
  endfunction

  function automatic bit m_cu_run(input int i, input int t);
    return act && mmask[i] && (t >= t0 + 1 + CLK_D) && (tcr[i] < 0 || t < tcr[i]);
  endfunction

  function automatic bit m_l2_on(input int t);
    return act && (t >= t0 + 1) && !(trst >= 0 && t >= trst + RST_D);
  endfunction

  function automatic bit m_l2_run(input int t);
    return act && (t >= t0 + 1 + CLK_D) && (trst < 0);
  endfunction

  function automatic bit m_done(input int t);
    return act && (trst >= 0) && (t == trst + RST_D);
  endfunction

  always @(posedge clk or negedge rst_ni) begin : model
    int             t;
    logic [NCU-1:0] go;
    bit             all_off;
    bit             l2go;
    bit             fin;
    if (!rst_ni) begin
      act    = 1'b0;
      mmask  = '0;
      msleep = '0;
      mabort = 1'b0;
      tnow   = 0;
      t0     = 0;
      trst   = -1;
      foreach (tcr[i]) tcr[i] = -1;
    end else begin
      t       = tnow;
      go      = '0;
      all_off = 1'b1;
      for (int i = 0; i < NCU; i++) begin
        go[i] = m_cu_run(i, t) && ((msleep[i] && !cu_delay_sleep_i[i]) || mabort);
        if (m_cu_on(i, t)) all_off = 1'b0;
      end
      l2go = m_l2_run(t) && all_off;
      fin  = m_done(t);
      if (fin) mabort = 1'b0;
      else if (gpu_abort_i && act) mabort = 1'b1;
      if (act && t == t0) msleep = '0;
      else msleep = msleep | cu_sleep_req_i;
      for (int i = 0; i < NCU; i++) if (go[i]) tcr[i] = t + 1;
      if (l2go) trst = t + 1;
      if (fin) begin
        act = 1'b0;
      end else if (!act && gpu_start_i && (cu_mask_i != '0)) begin
        act   = 1'b1;
        t0    = t + 1;
        trst  = -1;
        mmask = cu_mask_i;
        foreach (tcr[i]) tcr[i] = -1;
      end
      tnow = t + 1;
    end
  end

  // Per-cycle sample log for the directed timing checks.
  int             cyc = 0;
  logic           lg_busy[LOGN];
  logic [NCU-1:0] lg_clk[LOGN];
  logic [NCU-1:0] lg_rstn[LOGN];
  logic           lg_done[LOGN];
  logic           lg_l2rn[LOGN];
  logic           lg_l2clk[LOGN];
  logic           lg_abort[LOGN];

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin : compare
    logic [NCU-1:0] e_clk;
    logic [NCU-1:0] e_rstn;
    if (chk_en) begin
      e_clk  = '0;
      e_rstn = '0;
      for (int i = 0; i < NCU; i++) begin
        e_clk[i]  = m_cu_on(i, tnow);
        e_rstn[i] = m_cu_run(i, tnow);
      end
      chk("busy_o",      32'(busy_o),      32'(act));
      chk("done_o",      32'(done_o),      32'(m_done(tnow)));
      chk("l2_clk_en_o", 32'(l2_clk_en_o), 32'(m_l2_on(tnow)));
      chk("l2_rst_n_o",  32'(l2_rst_n_o),  32'(m_l2_run(tnow)));
      chk("cu_clk_en_o", 32'(cu_clk_en_o), 32'(e_clk));
      chk("cu_rst_n_o",  32'(cu_rst_n_o),  32'(e_rstn));
      if (cyc < LOGN) begin
        lg_busy[cyc]  = busy_o;
        lg_clk[cyc]   = cu_clk_en_o;
        lg_rstn[cyc]  = cu_rst_n_o;
        lg_done[cyc]  = done_o;
        lg_l2rn[cyc]  = l2_rst_n_o;
        lg_l2clk[cyc] = l2_clk_en_o;
        lg_abort[cyc] = gpu_abort_i;
      end
      cyc++;
    end
  end

  function automatic logic [NCU-1:0] lg_get(input int sel, input int j);
    case (sel)
      SEL_BUSY:  return {{(NCU-1){1'b0}}, lg_busy[j]};
      SEL_CLK:   return lg_clk[j];
      SEL_RSTN:  return lg_rstn[j];
      SEL_DONE:  return {{(NCU-1){1'b0}}, lg_done[j]};
      SEL_L2RN:  return {{(NCU-1){1'b0}}, lg_l2rn[j]};
      SEL_L2CLK: return {{(NCU-1){1'b0}}, lg_l2clk[j]};
      default:   return {{(NCU-1){1'b0}}, lg_abort[j]};
    endcase
  endfunction

  // First logged cycle at or after 'from' where the selected signal equals val; -1 if none.
  function automatic int find(input int from, input int sel, input logic [NCU-1:0] val);
    if (from < 0) return -1;
    for (int j = from; j < cyc && j < LOGN; j++) begin
      if (lg_get(sel, j) === val) return j;
    end
    return -1;
  endfunction

  function automatic int count_done(input int from);
    int n;
    n = 0;
    for (int j = from; j < cyc && j < LOGN; j++) if (lg_done[j] === 1'b1) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [NCU-1:0] m);
    cu_mask_i   = m;
    gpu_start_i = 1'b1;
    tick();
    gpu_start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int k;
    k = 0;
    while (busy_o && k < lim) begin
      tick();
      k++;
    end
    chk(name, 32'(busy_o), 32'd0);
    repeat (2) tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int mark;
    int b, c, r, f, d, a, n13, k;
    repeat (2) tick();
    chk_en = 1'b1;
    tick();
    // Reset state, pinned literally.
    chk("reset busy",   32'(busy_o),      32'd0);
    chk("reset done",   32'(done_o),      32'd0);
    chk("reset cu_clk", 32'(cu_clk_en_o), 32'd0);
    chk("reset cu_rst", 32'(cu_rst_n_o),  32'd0);
    chk("reset l2",     32'({l2_clk_en_o, l2_rst_n_o}), 32'd0);
    rst_ni = 1'b1;
    repeat (2) tick();

    // A: full mask, all CUs sleep 20 cycles after launch.
    mark = cyc;
    launch(4'b1111);
    repeat (20) tick();
    cu_sleep_req_i = 4'b1111;
    tick();
    cu_sleep_req_i = '0;
    wait_idle("A idle", 100);
    b = find(mark, SEL_BUSY, 4'b0001);
    c = find(b, SEL_CLK, 4'b1111);
    r = find(c, SEL_RSTN, 4'b1111);
    f = find(r, SEL_RSTN, 4'b0000);
    d = find(f, SEL_DONE, 4'b0001);
    chk("A clk_en one cycle after START", 32'(c - b), 32'd1);
    chk("A rst_n release after CLK_DELAY", 32'(r - c), 32'd4);
    chk("A CU reset phase length", 32'(find(f, SEL_CLK, 4'b0000) - f), 32'd4);
    chk("A L2 reset after last CU off", 32'(find(f, SEL_L2RN, 4'b0000) - f), 32'd5);
    chk("A L2 reset phase length",
        32'(find(f, SEL_L2CLK, 4'b0000) - find(f, SEL_L2RN, 4'b0000)), 32'd4);
    chk("A done after CU reset", 32'(d - f), 32'd9);
    chk("A done single pulse", 32'(count_done(mark)), 32'd1);

    // B: sparse mask, only CU0 and CU2 sleep.
    mark = cyc;
    launch(4'b0101);
    repeat (15) tick();
    cu_sleep_req_i = 4'b0101;
    tick();
    cu_sleep_req_i = '0;
    wait_idle("B idle", 100);
    n13 = 0;
    for (int j = mark; j < cyc; j++) if ((lg_clk[j] & 4'b1010) != 4'b0000) n13++;
    chk("B unmasked CUs stay off", 32'(n13), 32'd0);
    chk("B masked CUs reach RUN", 32'(find(mark, SEL_RSTN, 4'b0101) >= 0), 32'd1);
    chk("B done single pulse", 32'(count_done(mark)), 32'd1);

    // C: CU2 keeps draining for 10 cycles after its sleep request.
    mark = cyc;
    cu_delay_sleep_i = 4'b0100;
    launch(4'b1111);
    repeat (14) tick();
    cu_sleep_req_i = 4'b1111;
    tick();
    cu_sleep_req_i = '0;
    repeat (10) tick();
    cu_delay_sleep_i = '0;
    wait_idle("C idle", 100);
    r = find(mark, SEL_RSTN, 4'b0100);
    f = find(r, SEL_RSTN, 4'b0000);
    chk("C CU2 held in RUN", 32'(f - r), 32'd10);
    chk("C L2 waits for CU2", 32'(find(f, SEL_L2RN, 4'b0000) - f), 32'd5);

    // D: abort 3 cycles into L2_RUN with no sleep requests.
    mark = cyc;
    launch(4'b1111);
    k = 0;
    while (!l2_rst_n_o && k < 50) begin
      tick();
      k++;
    end
    repeat (3) tick();
    gpu_abort_i = 1'b1;
    tick();
    gpu_abort_i = 1'b0;
    wait_idle("D idle", 100);
    a = find(mark, SEL_ABORT, 4'b0001);
    f = find(a, SEL_RSTN, 4'b0000);
    d = find(f, SEL_DONE, 4'b0001);
    chk("D abort to CU reset", 32'(f - a), 32'd2);
    chk("D all CUs running before abort", 32'(lg_get(SEL_RSTN, f - 1)), 32'hF);
    chk("D done after abort reset", 32'(d - f), 32'd9);

    // E: start with empty mask and abort while idle are both ignored.
    mark = cyc;
    cu_mask_i   = '0;
    gpu_start_i = 1'b1;
    gpu_abort_i = 1'b1;
    repeat (3) tick();
    gpu_start_i = 1'b0;
    gpu_abort_i = 1'b0;
    tick();
    chk("E empty mask ignored", 32'(find(mark, SEL_BUSY, 4'b0001)), 32'hFFFF_FFFF);

    // F: async reset mid-run, then relaunch with only CU0.
    launch(4'b1111);
    repeat (8) tick();
    cu_delay_sleep_i = 4'b1111;
    cu_sleep_req_i   = 4'b1111;
    tick();
    cu_sleep_req_i = '0;
    repeat (2) tick();
    rst_ni = 1'b0;
    #1;
    chk("F reset gates CU clocks", 32'(cu_clk_en_o), 32'd0);
    chk("F reset asserts L2", 32'({l2_clk_en_o, l2_rst_n_o, busy_o}), 32'd0);
    tick();
    rst_ni = 1'b1;
    cu_delay_sleep_i = '0;
    tick();
    launch(4'b0001);
    repeat (12) tick();
    chk("F old sleep lost", 32'(cu_rst_n_o), 32'd1);
    cu_sleep_req_i = 4'b0001;
    tick();
    cu_sleep_req_i = '0;
    wait_idle("F idle", 100);

    // Random launches against the model.
    for (int it = 0; it < 30; it++) begin
      launch(NCU'($urandom));
      k = 0;
      do begin
        if (k < 150) begin
          for (int bi = 0; bi < NCU; bi++) cu_sleep_req_i[bi] = ($urandom_range(0, 15) == 0);
          if ($urandom_range(0, 7) == 0) cu_delay_sleep_i = NCU'($urandom);
          gpu_abort_i = ($urandom_range(0, 59) == 0);
          gpu_start_i = ($urandom_range(0, 19) == 0);
          cu_mask_i   = NCU'($urandom);
        end else begin
          cu_sleep_req_i   = '1;
          cu_delay_sleep_i = '0;
          gpu_abort_i      = 1'b0;
          gpu_start_i      = 1'b0;
        end
        tick();
        k++;
      end while (busy_o && k < 400);
      chk("random launch completes", 32'(busy_o), 32'd0);
      gpu_start_i      = 1'b0;
      cu_sleep_req_i   = '0;
      cu_delay_sleep_i = '0;
      gpu_abort_i      = ($urandom_range(0, 3) == 0);
      tick();
      gpu_abort_i = 1'b0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
